// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MIPS core's data side.
//   * Word port: combinational read, zero-wait-state byte-lane write.
//   * Block port: 256-bit (8-word) read/write through a four-state FSM
//     (IDLE -> WAIT -> XFER -> DONE) with programmable latency. The block
//     transfer moves one word per cycle, so a slow memory is modelled.
//
// Optional feature macro: DMEM_ERROR_EN
//   Defined   : Error_OUT is a sticky flag for misaligned word writes,
//               word writes while busy and dual block requests;
//               misaligned writes are suppressed.
//   Undefined : Error_OUT is tied 0; misaligned writes store lanes o..3.
//
// Ports
//   CLOCK            in   1   sole clock, rising edge
//   RESET            in   1   asynchronous active-low reset
//   Address_IN       in  32   byte address (upper bits alias)
//   Data_IN          in  32   word-write data, right-justified
//   DataSize_IN      in   2   byte count (0 means 4)
//   MemRead_IN       in   1   word read request
//   MemWrite_IN      in   1   word write request
//   MemBlockRead_IN  in   1   block read request
//   MemBlockWrite_IN in   1   block write request
//   DataBlock_IN     in 256   block write data, word 0 in [255:224]
//   Data_OUT         out 32   word read data (0 when not reading)
//   DataBlock_OUT    out 256  block read data, word 0 in [255:224]
//   Busy_OUT         out  1   block operation in progress
//   BlockValid_OUT   out  1   one-cycle completion pulse
//   Error_OUT        out  1   sticky protocol-error flag
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int BLOCK_LATENCY = 4
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [31:0]  Address_IN,
  input  logic [31:0]  Data_IN,
  input  logic [1:0]   DataSize_IN,
  input  logic         MemRead_IN,
  input  logic         MemWrite_IN,
  input  logic         MemBlockRead_IN,
  input  logic         MemBlockWrite_IN,
  input  logic [255:0] DataBlock_IN,
  output logic [31:0]  Data_OUT,
  output logic [255:0] DataBlock_OUT,
  output logic         Busy_OUT,
  output logic         BlockValid_OUT,
  output logic         Error_OUT
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int BASE_W = ADDR_WIDTH - 3;
  // WAIT counts down from LAT_LOAD to 0, giving BLOCK_LATENCY wait cycles.
  localparam logic [3:0] LAT_LOAD = (BLOCK_LATENCY > 0) ? 4'(BLOCK_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          wait_cnt_reg, wait_cnt_next;
  logic [2:0]          beat_reg, beat_next;
  logic [BASE_W-1:0]   base_reg;
  logic                op_write_reg;
  logic [255:0]        wbuf_reg;
  logic [255:0]        rbuf_reg;

  logic [31:0]         mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  idle;
  logic                  blk_accept;
  logic                  word_wr_go;
  logic [31:0]           beat_rd_word;
  logic [31:0]           beat_wr_word;

  // Address bits above the memory size alias and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address_IN[31:ADDR_WIDTH+2];

  assign word_idx  = Address_IN[ADDR_WIDTH+1:2];
  assign beat_addr = {base_reg, beat_reg};
  assign idle      = (state_reg == S_IDLE);

  // -------------------------------------------------------------------------
  // Word read: combinational, honoured in every FSM state.
  // -------------------------------------------------------------------------
  assign Data_OUT = MemRead_IN ? mem[word_idx] : 32'd0;

  // -------------------------------------------------------------------------
  // Byte-lane steering for word writes (big-endian: lane 0 = bits [31:24]).
  // The n-byte value is shifted so its last byte lands on lane o+n-1. When
  // o+n>4 no shift is applied, so lanes o..3 receive the low 4-o bytes.
  // -------------------------------------------------------------------------
  logic [1:0]  offset;
  logic [2:0]  size_n;
  logic [2:0]  end_lane;
  logic        misaligned;
  logic [1:0]  shift_bytes;
  logic [31:0] steered;
  logic [3:0]  lane_sel;

  assign offset      = Address_IN[1:0];
  assign size_n      = (DataSize_IN == 2'd0) ? 3'd4 : {1'b0, DataSize_IN};
  assign end_lane    = {1'b0, offset} + size_n;
  assign misaligned  = (end_lane > 3'd4);
  assign shift_bytes = misaligned ? 2'd0 : 2'(3'd4 - end_lane);
  assign steered     = Data_IN << {shift_bytes, 3'b000};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sel[gi] = (3'(gi) >= {1'b0, offset}) && (3'(gi) < end_lane);
    end
  endgenerate

`ifdef DMEM_ERROR_EN
  assign word_wr_go = MemWrite_IN && idle && !misaligned;
`else
  assign word_wr_go = MemWrite_IN && idle;
`endif

  // Exactly one block request is required; a dual request is rejected.
  assign blk_accept = idle && (MemBlockRead_IN ^ MemBlockWrite_IN);

  // -------------------------------------------------------------------------
  // Single memory write port. Block beats (XFER only) and word writes
  // (IDLE only) are mutually exclusive by construction.
  // -------------------------------------------------------------------------
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign beat_wr_word = wbuf_reg[{~beat_reg, 5'b00000} +: 32];
  assign beat_rd_word = mem[beat_addr];

  always_comb begin
    mem_we    = 4'b0000;
    mem_waddr = word_idx;
    mem_wdata = steered;
    if (state_reg == S_XFER && op_write_reg) begin
      mem_we    = 4'b1111;
      mem_waddr = beat_addr;
      mem_wdata = beat_wr_word;
    end else if (word_wr_go) begin
      mem_we = lane_sel;
    end
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge CLOCK) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) begin
        mem[mem_waddr][8*(3-k) +: 8] <= mem_wdata[8*(3-k) +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      beat_reg     <= 3'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      beat_reg     <= beat_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    beat_next     = beat_reg;
    case (state_reg)
      S_IDLE: begin
        if (blk_accept) begin
          state_next    = (BLOCK_LATENCY == 0) ? S_XFER : S_WAIT;
          wait_cnt_next = LAT_LOAD;
          beat_next     = 3'd0;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = S_XFER;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      S_XFER: begin
        if (beat_reg == 3'd7) begin
          state_next = S_DONE;
          beat_next  = 3'd0;
        end else begin
          beat_next = beat_reg + 3'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    Busy_OUT       = (state_reg != S_IDLE);
    BlockValid_OUT = (state_reg == S_DONE);
  end

  assign DataBlock_OUT = rbuf_reg;

  // -------------------------------------------------------------------------
  // Block datapath: request latch, write buffer, read buffer.
  // The read buffer is only touched by read beats, so it holds the last
  // completed block read across block writes.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      base_reg     <= '0;
      op_write_reg <= 1'b0;
      wbuf_reg     <= '0;
      rbuf_reg     <= '0;
    end else begin
      if (blk_accept) begin
        base_reg     <= Address_IN[ADDR_WIDTH+1:5];
        op_write_reg <= MemBlockWrite_IN;
        if (MemBlockWrite_IN) begin
          wbuf_reg <= DataBlock_IN;
        end
      end
      if (state_reg == S_XFER && !op_write_reg) begin
        rbuf_reg[{~beat_reg, 5'b00000} +: 32] <= beat_rd_word;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Protocol-error flag
  // -------------------------------------------------------------------------
`ifdef DMEM_ERROR_EN
  logic error_reg;
  logic err_event;

  assign err_event = (MemWrite_IN && (!idle || misaligned)) ||
                     (MemBlockRead_IN && MemBlockWrite_IN);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      error_reg <= 1'b0;
    end else if (err_event) begin
      error_reg <= 1'b1;
    end
  end

  assign Error_OUT = error_reg;
`else
  assign Error_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed, self-checking bench for dmem_responder (default parameters:
// ADDR_WIDTH=10, BLOCK_LATENCY=4). Works with or without DMEM_ERROR_EN.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic         CLOCK;
  logic         RESET;
  logic [31:0]  Address_IN;
  logic [31:0]  Data_IN;
  logic [1:0]   DataSize_IN;
  logic         MemRead_IN;
  logic         MemWrite_IN;
  logic         MemBlockRead_IN;
  logic         MemBlockWrite_IN;
  logic [255:0] DataBlock_IN;
  logic [31:0]  Data_OUT;
  logic [255:0] DataBlock_OUT;
  logic         Busy_OUT;
  logic         BlockValid_OUT;
  logic         Error_OUT;

`ifdef DMEM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int   tests = 0;
  int   fails = 0;
  logic err_exp;

  dmem_responder #(
    .ADDR_WIDTH    (10),
    .BLOCK_LATENCY (4)
  ) dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .Address_IN       (Address_IN),
    .Data_IN          (Data_IN),
    .DataSize_IN      (DataSize_IN),
    .MemRead_IN       (MemRead_IN),
    .MemWrite_IN      (MemWrite_IN),
    .MemBlockRead_IN  (MemBlockRead_IN),
    .MemBlockWrite_IN (MemBlockWrite_IN),
    .DataBlock_IN     (DataBlock_IN),
    .Data_OUT         (Data_OUT),
    .DataBlock_OUT    (DataBlock_OUT),
    .Busy_OUT         (Busy_OUT),
    .BlockValid_OUT   (BlockValid_OUT),
    .Error_OUT        (Error_OUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [255:0] seq_block(input logic [31:0] first);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[255-32*i -: 32] = first + 32'(i);
    end
    return b;
  endfunction

  task automatic word_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    Address_IN  = addr;
    Data_IN     = data;
    DataSize_IN = size;
    MemWrite_IN = 1'b1;
    step();
    MemWrite_IN = 1'b0;
    $display("[TB] word write addr=%h data=%h size=%0d", addr, data, size);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address_IN = addr;
    MemRead_IN = 1'b1;
    #1;
    chk(tag, Data_OUT, exp);
    $display("[TB] word read addr=%h data=%h", addr, Data_OUT);
    MemRead_IN = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && Busy_OUT; i++) step();
    chk(tag, Busy_OUT, 1'b0);
  endtask

  // Issues one block request (optionally with a word write in the same
  // cycle) and measures the busy window.
  task automatic run_block(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [255:0] blk,
                           input logic ww, input logic [31:0] wdata,
                           output int busy_cnt, output int valid_cnt, output int valid_at);
    Address_IN       = addr;
    DataBlock_IN     = blk;
    MemBlockRead_IN  = rd;
    MemBlockWrite_IN = wr;
    MemWrite_IN      = ww;
    Data_IN          = wdata;
    DataSize_IN      = 2'd0;
    step();
    MemBlockRead_IN  = 1'b0;
    MemBlockWrite_IN = 1'b0;
    MemWrite_IN      = 1'b0;
    busy_cnt  = 0;
    valid_cnt = 0;
    valid_at  = 0;
    for (int i = 0; i < 40 && Busy_OUT; i++) begin
      busy_cnt++;
      if (BlockValid_OUT) begin
        valid_cnt++;
        valid_at = busy_cnt;
      end
      step();
    end
    chk({tag, "_idle"}, Busy_OUT, 1'b0);
    $display("[TB] %s addr=%h busy=%0d valid_at=%0d", tag, addr, busy_cnt, valid_at);
  endtask

  initial begin
    int           bc, vc, va;
    logic [31:0]  w40;
    logic [255:0] blk_exp;

    RESET            = 1'b0;
    Address_IN       = '0;
    Data_IN          = '0;
    DataSize_IN      = '0;
    MemRead_IN       = 1'b0;
    MemWrite_IN      = 1'b0;
    MemBlockRead_IN  = 1'b0;
    MemBlockWrite_IN = 1'b0;
    DataBlock_IN     = '0;
    err_exp          = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", Busy_OUT, 1'b0);
    chk("rst_valid", BlockValid_OUT, 1'b0);
    chk("rst_block", DataBlock_OUT, '0);
    chk("rst_err", Error_OUT, 1'b0);
    chk("rst_data", Data_OUT, 32'd0);
    step();
    step();
    RESET = 1'b1;
    step();

    // Full word write, visible the cycle after the edge
    word_write(32'h40, 32'hDEADBEEF, 2'd0);
    read_chk("word_full", 32'h40, 32'hDEADBEEF);
    Address_IN = 32'h40;
    #1;
    chk("read_gated", Data_OUT, 32'd0);
    read_chk("word_alias", 32'h1000_0040, 32'hDEADBEEF);

    // Byte, half and three-byte lane writes
    word_write(32'h40, 32'h11223344, 2'd0);
    word_write(32'h42, 32'h000000AA, 2'd1);
    read_chk("byte_wr", 32'h40, 32'h1122AA44);
    word_write(32'h42, 32'h0000BBCC, 2'd2);
    read_chk("half_wr", 32'h40, 32'h1122BBCC);
    word_write(32'h41, 32'h00556677, 2'd3);
    read_chk("tri_wr", 32'h40, 32'h11556677);

    // Misaligned writes: suppressed with error, else lanes o..3 only
    word_write(32'h43, 32'h0000BBCC, 2'd2);
    if (ERR_EN) begin
      w40     = 32'h11556677;
      err_exp = 1'b1;
    end else begin
      w40 = 32'h115566CC;
    end
    read_chk("mis_half", 32'h40, w40);
    chk("mis_err", Error_OUT, err_exp);
    word_write(32'h44, 32'hFFFFFFFF, 2'd0);
    word_write(32'h46, 32'h00ABCDEF, 2'd3);
    read_chk("mis_tri", 32'h44, ERR_EN ? 32'hFFFFFFFF : 32'hFFFFCDEF);

    // Block write: 13 busy cycles, valid pulse in the last one
    run_block("blk_wr", 1'b0, 1'b1, 32'h100, seq_block(32'h0), 1'b0, 32'h0, bc, vc, va);
    chk("blk_wr_busy", 32'(bc), 32'd13);
    chk("blk_wr_vcnt", 32'(vc), 32'd1);
    chk("blk_wr_vat", 32'(va), 32'd13);
    read_chk("blk_wr_w0", 32'h100, 32'h0);
    read_chk("blk_wr_w3", 32'h10C, 32'h3);
    read_chk("blk_wr_w7", 32'h11C, 32'h7);

    // Block read through an aliased address (low 5 bits ignored)
    run_block("blk_rd", 1'b1, 1'b0, 32'h11C, '1, 1'b0, 32'h0, bc, vc, va);
    chk("blk_rd_busy", 32'(bc), 32'd13);
    chk("blk_rd_data", DataBlock_OUT, seq_block(32'h0));
    chk("blk_rd_w0", DataBlock_OUT[255:224], 32'h0);
    chk("blk_rd_w7", DataBlock_OUT[31:0], 32'h7);

    // Word write during XFER is dropped; reads still served while busy
    Address_IN       = 32'h200;
    DataBlock_IN     = seq_block(32'hA0);
    MemBlockWrite_IN = 1'b1;
    step();
    MemBlockWrite_IN = 1'b0;
    repeat (5) step();
    chk("xfer_busy", Busy_OUT, 1'b1);
    word_write(32'h40, 32'hCAFEF00D, 2'd0);
    if (ERR_EN) err_exp = 1'b1;
    chk("busy_wr_err", Error_OUT, err_exp);
    read_chk("busy_rd", 32'h40, w40);
    wait_idle("busy_wr_idle");
    read_chk("busy_wr_drop", 32'h40, w40);
    read_chk("blk2_w0", 32'h200, 32'hA0);
    read_chk("blk2_w7", 32'h21C, 32'hA7);
    chk("blk_wr_keeps_rd", DataBlock_OUT, seq_block(32'h0));

    // Dual block request: rejected, nothing changes
    word_write(32'h300, 32'h55AA55AA, 2'd0);
    Address_IN       = 32'h300;
    DataBlock_IN     = '1;
    MemBlockRead_IN  = 1'b1;
    MemBlockWrite_IN = 1'b1;
    step();
    MemBlockRead_IN  = 1'b0;
    MemBlockWrite_IN = 1'b0;
    if (ERR_EN) err_exp = 1'b1;
    chk("dual_busy", Busy_OUT, 1'b0);
    chk("dual_err", Error_OUT, err_exp);
    step();
    chk("dual_busy2", Busy_OUT, 1'b0);
    read_chk("dual_mem", 32'h300, 32'h55AA55AA);
    chk("dual_rdbuf", DataBlock_OUT, seq_block(32'h0));

    // Word write and block read in the same IDLE cycle
    run_block("wr_and_rd", 1'b1, 1'b0, 32'h104, '0, 1'b1, 32'h12345678, bc, vc, va);
    blk_exp = seq_block(32'h0);
    blk_exp[223:192] = 32'h12345678;
    chk("wr_and_rd_blk", DataBlock_OUT, blk_exp);
    read_chk("wr_and_rd_mem", 32'h104, 32'h12345678);

    // Reset asserted during beat 3 of a block write
    Address_IN       = 32'h100;
    DataBlock_IN     = seq_block(32'hB0);
    MemBlockWrite_IN = 1'b1;
    step();
    MemBlockWrite_IN = 1'b0;
    repeat (7) step();
    chk("pre_abort_busy", Busy_OUT, 1'b1);
    RESET = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("abort_busy", Busy_OUT, 1'b0);
    chk("abort_valid", BlockValid_OUT, 1'b0);
    chk("abort_block", DataBlock_OUT, '0);
    chk("abort_err", Error_OUT, err_exp);
    step();
    step();
    RESET = 1'b1;
    step();
    read_chk("abort_w0", 32'h100, 32'hB0);
    read_chk("abort_w2", 32'h108, 32'hB2);
    read_chk("abort_w3", 32'h10C, 32'h3);
    read_chk("abort_w7", 32'h11C, 32'h7);

    // Next request after reset is accepted normally
    run_block("post_rst_rd", 1'b1, 1'b0, 32'h100, '0, 1'b0, 32'h0, bc, vc, va);
    chk("post_rst_busy", 32'(bc), 32'd13);
    blk_exp = seq_block(32'h0);
    blk_exp[255:224] = 32'hB0;
    blk_exp[223:192] = 32'hB1;
    blk_exp[191:160] = 32'hB2;
    chk("post_rst_blk", DataBlock_OUT, blk_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves the MIPS core's data-side memory interface. It implements the word/byte port (`MemRead`/`MemWrite` with `DataSize`) and the 256-bit block port (`MemBlockRead`/`MemBlockWrite`). Word accesses complete with zero wait states. Block accesses run through a multi-cycle state machine with programmable latency and a busy indication, which gives the future cache controller a realistic slow-memory target. The block sits directly opposite the core's `DataAddress`/`Data`/`DataSize`/`MemRead`/`MemWrite`/`DataBlock`/`MemBlock*` outputs.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: log2 of the number of 32-bit words; memory holds 2^ADDR_WIDTH words.
- `BLOCK_LATENCY`, default 4: number of WAIT cycles before the first block beat; legal range 0..15.

Ports:
- `CLOCK` in 1: sole clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `Address_IN` in 32: byte address. Word index is `Address_IN[ADDR_WIDTH+1:2]`; higher bits are ignored and alias.
- `Data_IN` in 32: word-write data, right-justified.
- `DataSize_IN` in 2: byte count; 1 = 1, 2 = 2, 3 = 3, 0 = 4.
- `MemRead_IN` in 1: word read request.
- `MemWrite_IN` in 1: word write request.
- `MemBlockRead_IN` in 1: block read request.
- `MemBlockWrite_IN` in 1: block write request.
- `DataBlock_IN` in 256: block write data; word 0 in [255:224].
- `Data_OUT` out 32: word read data.
- `DataBlock_OUT` out 256: block read data; word 0 in [255:224].
- `Busy_OUT` out 1: block operation in progress.
- `BlockValid_OUT` out 1: one-cycle pulse when a block operation completes.
- `Error_OUT` out 1: sticky protocol-error flag.

## Operation

Byte order and word reads:
- Big-endian: byte offset 0 is bits [31:24].
- Word read is combinational. While `MemRead_IN`=1, `Data_OUT` = full aligned word at the word index; otherwise `Data_OUT` = 0.
- The core performs byte/half extraction and sign extension.
- Reads are honoured in every state, including while busy.

Word writes:
- Performed at the clock edge when `MemWrite_IN`=1 and the FSM is IDLE.
- Size n, offset o=`Address_IN[1:0]`: the low n bytes of `Data_IN` go to byte lanes o..o+n-1.
- Unselected lanes are unchanged.
- A write is misaligned when o+n>4.
- A word write while `Busy_OUT`=1 is dropped.

Block FSM, states IDLE, WAIT, XFER, DONE:
- IDLE: a block request is accepted at the edge when exactly one of `MemBlockRead_IN`/`MemBlockWrite_IN` is 1.
- On acceptance, the FSM latches block base `Address_IN[ADDR_WIDTH+1:5]` (low 5 bits ignored) and the op type.
- For a block write, `DataBlock_IN` is also latched into an internal buffer.
- Next state is WAIT, or XFER if BLOCK_LATENCY=0.
- Both block requests asserted together: neither is accepted, FSM stays IDLE.
- WAIT: down-counter loaded with BLOCK_LATENCY-1; moves to XFER when the count reaches 0.
- XFER: 3-bit beat counter 0..7, one word per cycle. Read copies `mem[base*8+beat]` into the DataBlock_OUT buffer slot `beat`. Write stores buffer slot `beat` into `mem[base*8+beat]`. Moves to DONE after beat 7.
- DONE: `BlockValid_OUT`=1 for one cycle, then IDLE.
- `Busy_OUT`=1 in WAIT, XFER and DONE.
- Requests presented while busy are ignored, not queued; the requester must hold or re-issue them.
- `DataBlock_OUT` holds its value from DONE until the next block read's first beat. Block writes do not alter it.
- A word write and a block request in the same IDLE cycle: both are taken. A block read then observes the new word.

Reset:
- FSM = IDLE, counters = 0, `Busy_OUT`=0, `BlockValid_OUT`=0, `DataBlock_OUT`=0, `Error_OUT`=0.
- Memory array is not cleared.
- Reset during WAIT/XFER aborts the operation. Beats already written stay written; remaining beats are not written.

## Timing

- Word read: 0-cycle latency, combinational from `Address_IN`/`MemRead_IN`.
- Word write: visible to a read in the cycle after the edge.
- Block: request sampled at edge E. `Busy_OUT` rises after E and stays high for BLOCK_LATENCY+9 cycles.
- `BlockValid_OUT` is high in the final cycle of that window.
- The earliest next acceptance is at the edge ending DONE+1 (the first IDLE cycle).
- Default BLOCK_LATENCY=4: 13 busy cycles.

## Configuration

`DMEM_ERROR_EN`:
- Defined: `Error_OUT` is set at the edge of any misaligned word write, word write while busy, or dual block request. It stays set until reset, and the misaligned write is suppressed entirely.
- Undefined: `Error_OUT` is tied 0. Misaligned writes store only lanes o..3, taking the low 4-o bytes of the n selected bytes and discarding the rest. Dropped busy writes and rejected dual requests behave identically to the defined case.

## Test plan

- Write 0xDEADBEEF at addr 0x40 with size 0, then read 0x40: `Data_OUT`=0xDEADBEEF in the cycle after the write.
- Byte write 0x000000AA, size 1, addr 0x42, over 0x11223344 at 0x40: read returns 0x1122AA44. Half write 0xBBCC at offset 2: read returns 0x1122BBCC.
- Block write at 0x100 with words 0x0..0x7, BLOCK_LATENCY=4: `Busy_OUT` high exactly 13 cycles, `BlockValid_OUT` only in cycle 13. Then a block read at 0x11C (aliases to 0x100) gives `DataBlock_OUT`[255:224]=0, [31:0]=7.
- Word write issued during XFER: dropped, memory unchanged; with `DMEM_ERROR_EN`, `Error_OUT`=1 from the next cycle. Word write of size 2 at offset 3: suppressed and `Error_OUT`=1.
- Both block requests together in IDLE: `Busy_OUT` stays 0, no memory change.
- Assert `RESET`=0 at beat 3 of a block write: all outputs go to reset values asynchronously; words 0..2 written, words 3..7 unchanged; the next request is accepted normally.
